// File: rtl/div_sequencer.sv
// div_sequencer: request/response wrapper around an external iterative signed
// divider. It screens out divide-by-zero and the single overflow case, sequences
// the divider's load/run window, and holds the result until downstream takes it.
module div_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_dd,
  input  logic [N-1:0] in_dr,
  output logic         div_load,
  output logic [N-1:0] div_dd,
  output logic [N-1:0] div_dr,
  input  logic [N-1:0] div_q,
  input  logic [N-1:0] div_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic [N-1:0] out_r,
  output logic         out_dbz,
  output logic         out_ovf,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          accept_c;
  logic          dbz_c;
  logic          ovf_c;

  // Request classification on the raw inputs at the accept edge.
  assign accept_c = in_valid && in_ready;
  assign dbz_c    = (in_dr == '0);
  assign ovf_c    = (in_dd == MOST_NEG) && (in_dr == '1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept_c) state_n = (dbz_c || ovf_c) ? DONE : LOAD;
      LOAD: state_n = RUN;
      RUN:  if (cnt == CW'(1)) state_n = CAPT;
      CAPT: state_n = DONE;
      DONE: if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status strobes registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      busy     <= 1'b0;
      div_load <= 1'b0;
    end else begin
      in_ready <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
      div_load <= (state_n == LOAD);
    end
  end

  // RUN window down-counter: loaded with N leaving LOAD, exits RUN at 1.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state == LOAD) cnt <= CW'(N);
    else if (state == RUN)  cnt <= cnt - CW'(1);
  end

  // Operand registers feed the divider and ignore inputs until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_dd <= '0;
      div_dr <= '0;
    end else if (accept_c) begin
      div_dd <= in_dd;
      div_dr <= in_dr;
    end
  end

  // Result registers: early-exit results at accept, divider results in CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      out_r   <= '0;
      out_dbz <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept_c && dbz_c) begin
      out_q   <= '1;
      out_r   <= in_dd;
      out_dbz <= 1'b1;
      out_ovf <= 1'b0;
    end else if (accept_c && ovf_c) begin
      out_q   <= in_dd;
      out_r   <= '0;
      out_dbz <= 1'b0;
      out_ovf <= 1'b1;
    end else if (state == CAPT) begin
      out_q   <= div_q;
      out_r   <= div_r;
      out_dbz <= 1'b0;
      out_ovf <= 1'b0;
    end
  end

  // Result valid: rises with the CAPT->DONE edge; early-exit results settle in
  // DONE for one cycle first, giving them a fixed one-edge latency.
  always_ff @(posedge clk) begin
    if (rst)                             out_valid <= 1'b0;
    else if (out_valid && out_ready)     out_valid <= 1'b0;
    else if (state == CAPT || state == DONE) out_valid <= 1'b1;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (N=4) with a behavioural iterative divider.
module tb_div_sequencer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dd;
  logic [N-1:0] in_dr;
  logic         div_load;
  logic [N-1:0] div_dd;
  logic [N-1:0] div_dr;
  logic [N-1:0] div_q;
  logic [N-1:0] div_r;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_q;
  logic [N-1:0] out_r;
  logic         out_dbz;
  logic         out_ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  div_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dd    (in_dd),
    .in_dr    (in_dr),
    .div_load (div_load),
    .div_dd   (div_dd),
    .div_dr   (div_dr),
    .div_q    (div_q),
    .div_r    (div_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_r    (out_r),
    .out_dbz  (out_dbz),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Iterative divider model: result appears N edges after the load edge,
  // junk is driven meanwhile so an early capture is visible.
  logic signed [N-1:0] m_a;
  logic signed [N-1:0] m_b;
  int                  m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      div_q <= 4'hA;
      div_r <= 4'h6;
    end else if (div_load) begin
      m_a   <= div_dd;
      m_b   <= div_dr;
      m_cnt <= N;
      div_q <= 4'hA;
      div_r <= 4'h6;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      div_q <= m_a / m_b;
      div_r <= m_a % m_b;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dr;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           loads;
  } vec_t;

  vec_t vecs[12];

  // Issue one request, measure latency and div_load pulses, check the result,
  // optionally stall downstream for `hold` cycles, then complete the handshake.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int k;
    int loads;
    int lat;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_dd    = v.dd;
    in_dr    = v.dr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_dd    = ~v.dd;
    in_dr    = 4'h0;
    loads    = 0;
    lat      = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      loads = loads + int'(div_load);
      if (out_valid) lat = i;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " div_load pulses"}, 32'(loads), 32'(v.loads));
    check({tag, " div_dd held"}, 32'(div_dd), 32'(v.dd));
    check({tag, " div_dr held"}, 32'(div_dr), 32'(v.dr));
    check({tag, " out_q"}, 32'(out_q), 32'(v.q));
    check({tag, " out_r"}, 32'(out_r), 32'(v.r));
    check({tag, " out_dbz"}, 32'(out_dbz), 32'(v.dbz));
    check({tag, " out_ovf"}, 32'(out_ovf), 32'(v.ovf));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold out_q"}, 32'(out_q), 32'(v.q));
      check({tag, " hold out_r"}, 32'(out_r), 32'(v.r));
      check({tag, " hold flags"}, 32'({out_dbz, out_ovf}), 32'({v.dbz, v.ovf}));
    end
    @(negedge clk);
    check({tag, " in_ready in handshake cycle"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    //          dd     dr     q      r      dbz   ovf   lat loads
    vecs[0]  = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 6, 1};  //  7 /  2
    vecs[1]  = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 6, 1};  // -7 /  2
    vecs[2]  = '{4'h6, 4'hD, 4'hE, 4'h0, 1'b0, 1'b0, 6, 1};  //  6 / -3
    vecs[3]  = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 1, 0};  //  5 /  0
    vecs[4]  = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 1, 0};  // -8 / -1
    vecs[5]  = '{4'hF, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1, 0};  // -1 /  0
    vecs[6]  = '{4'h7, 4'hF, 4'h9, 4'h0, 1'b0, 1'b0, 6, 1};  //  7 / -1
    vecs[7]  = '{4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, 6, 1};  // -8 /  1
    vecs[8]  = '{4'h3, 4'h5, 4'h0, 4'h3, 1'b0, 1'b0, 6, 1};  //  3 /  5
    vecs[9]  = '{4'hB, 4'h3, 4'hF, 4'hE, 1'b0, 1'b0, 6, 1};  // -5 /  3
    vecs[10] = '{4'h8, 4'h7, 4'hF, 4'hF, 1'b0, 1'b0, 6, 1};  // -8 /  7
    vecs[11] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 6, 1};  //  0 / -1

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_dd     = '0;
    in_dr     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset div_load", 32'(div_load), 32'd0);
    check("reset out_q/out_r", 32'({out_q, out_r}), 32'd0);
    check("reset div_dd/div_dr", 32'({div_dd, div_dr}), 32'd0);
    check("reset flags", 32'({out_dbz, out_ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Downstream stall of 10 cycles in DONE.
    run_vec(vecs[0], 10, "stall");

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_dd    = 4'h7;
    in_dr    = 4'h2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort busy in RUN", 32'(busy), 32'd1);
    check("abort div_load low in RUN", 32'(div_load), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy after rst", 32'(busy), 32'd0);
    check("abort in_ready after rst", 32'(in_ready), 32'd1);
    check("abort out_q after rst", 32'(out_q), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    run_vec(vecs[0], 0, "after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
